traffic_light_monitor: RTL and testbench

- Passive protocol checker that sits on the six lamp outputs of the traffic light controller and consumes them.
- Each cycle it decodes every direction's lamp state and checks safety, sequence legality and phase timing.
- It raises per-cycle error pulses and sticky fault flags, and counts completed signal cycles per direction.
- Used in simulation benches and optionally instantiated in silicon as a safety watchdog.

---
 rtl/traffic_light_monitor.sv | 146 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-direction traffic light controller.
// It decodes the six lamp drives into one colour per direction every cycle.
// It flags the following:
//   - lamp patterns that are not one-hot;
//   - both directions being non-red at once;
//   - illegal colour orders;
//   - green and yellow phases of the wrong length.
// It also counts completed yellow-to-red transitions per direction.
// Every output is registered: a violation sampled at edge k appears on
// err_pulse just after edge k.
module traffic_light_monitor #(
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 50,
    parameter int YELLOW_CYC = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             NS_red,
    input  logic             NS_yellow,
    input  logic             NS_green,
    input  logic             EW_red,
    input  logic             EW_yellow,
    input  logic             EW_green,
    input  logic             clr_faults,
    output logic [3:0]       err_pulse,
    output logic [3:0]       fault_vec,
    output logic             fault,
    output logic [CNT_W-1:0] ns_cycles,
    output logic [CNT_W-1:0] ew_cycles
);

    typedef enum logic [2:0] {
        ST_NONE,
        ST_RED,
        ST_YELLOW,
        ST_GREEN,
        ST_INVALID
    } lamp_t;

    localparam logic [CNT_W-1:0] G_MIN   = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] G_MAX   = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] Y_CYC   = CNT_W'(YELLOW_CYC);
    localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};

    // Index 0 is north-south, index 1 is east-west.
    lamp_t            cur       [2];
    lamp_t            prev_q    [2];
    logic [CNT_W-1:0] dur_q     [2];
    logic             partial_q [2];
    logic [CNT_W-1:0] cyc_q     [2];

    logic             chg       [2];
    logic             vv_chg    [2];
    logic             seq_err   [2];
    logic             tim_err   [2];
    logic             y_to_r    [2];

    logic [3:0]       err_next;
    logic [3:0]       fault_next;

    function automatic lamp_t decode(input logic r, input logic y, input logic g);
        case ({r, y, g})
            3'b100:  return ST_RED;
            3'b010:  return ST_YELLOW;
            3'b001:  return ST_GREEN;
            default: return ST_INVALID;
        endcase
    endfunction

    function automatic logic is_colour(input lamp_t s);
        return (s == ST_RED) || (s == ST_YELLOW) || (s == ST_GREEN);
    endfunction

    // Decode the lamps and evaluate every check against the registered history.
    always_comb begin
        cur[0] = decode(NS_red, NS_yellow, NS_green);
        cur[1] = decode(EW_red, EW_yellow, EW_green);
        for (int i = 0; i < 2; i++) begin
            chg[i]     = (cur[i] != prev_q[i]);
            vv_chg[i]  = chg[i] && is_colour(prev_q[i]) && is_colour(cur[i]);
            y_to_r[i]  = (prev_q[i] == ST_YELLOW) && (cur[i] == ST_RED);
            seq_err[i] = vv_chg[i] &&
                         !(((prev_q[i] == ST_GREEN)  && (cur[i] == ST_YELLOW)) ||
                           y_to_r[i] ||
                           ((prev_q[i] == ST_RED)    && (cur[i] == ST_GREEN)));
            // A phase entered mid-way (after reset or an invalid pattern) is not timed.
            tim_err[i] = !partial_q[i] &&
                         ((chg[i] && (prev_q[i] == ST_GREEN) && (dur_q[i] < G_MIN)) ||
                          (chg[i] && (prev_q[i] == ST_YELLOW) && (dur_q[i] != Y_CYC)) ||
                          (!chg[i] && (cur[i] == ST_GREEN) && (dur_q[i] == G_MAX)));
        end
        err_next[0] = (cur[0] == ST_INVALID) || (cur[1] == ST_INVALID);
        err_next[1] = (cur[0] != ST_RED) && (cur[1] != ST_RED);
        err_next[2] = seq_err[0] || seq_err[1];
        err_next[3] = tim_err[0] || tim_err[1];
        // A new error arriving together with the clear still gets recorded.
        fault_next  = (clr_faults ? 4'b0000 : fault_vec) | err_next;
    end

    // Per-direction history: previous colour, phase length, partial flag, cycle count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                prev_q[i]    <= ST_NONE;
                dur_q[i]     <= '0;
                partial_q[i] <= 1'b1;
                cyc_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                prev_q[i] <= cur[i];
                if (chg[i]) begin
                    dur_q[i] <= CNT_W'(1);
                end else if (dur_q[i] != CNT_TOP) begin
                    dur_q[i] <= dur_q[i] + CNT_W'(1);
                end
                if (cur[i] == ST_INVALID) begin
                    partial_q[i] <= 1'b1;
                end else if (vv_chg[i]) begin
                    partial_q[i] <= 1'b0;
                end
                if (y_to_r[i] && (cyc_q[i] != CNT_TOP)) begin
                    cyc_q[i] <= cyc_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register the per-edge error pulse and the sticky fault flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse <= 4'b0000;
            fault_vec <= 4'b0000;
            fault     <= 1'b0;
        end else begin
            err_pulse <= err_next;
            fault_vec <= fault_next;
            fault     <= |fault_next;
        end
    end

    assign ns_cycles = cyc_q[0];
    assign ew_cycles = cyc_q[1];

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor.
// Each step drives one cycle of lamp patterns and queues the err_pulse expected
// just after that edge; the queue is popped and compared once the edge has passed.
// Counters and sticky flags are compared against values tracked by the bench.
module tb_traffic_light_monitor;

    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_Y   = 3'b010;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_BAD = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        NS_red, NS_yellow, NS_green;
    logic        EW_red, EW_yellow, EW_green;
    logic        clr_faults;
    logic [3:0]  err_pulse;
    logic [3:0]  fault_vec;
    logic        fault;
    logic [15:0] ns_cycles;
    logic [15:0] ew_cycles;

    logic [3:0]  exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          exp_ns   = 0;
    int          exp_ew   = 0;
    logic [3:0]  exp_fv   = 4'b0000;

    traffic_light_monitor #(
        .GREEN_MIN(10), .GREEN_MAX(50), .YELLOW_CYC(3), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .NS_red(NS_red), .NS_yellow(NS_yellow), .NS_green(NS_green),
        .EW_red(EW_red), .EW_yellow(EW_yellow), .EW_green(EW_green),
        .clr_faults(clr_faults),
        .err_pulse(err_pulse), .fault_vec(fault_vec), .fault(fault),
        .ns_cycles(ns_cycles), .ew_cycles(ew_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // Legal schedule, 27 cycles: NS G10 Y3 R14, EW R13 G10 Y3 R1.
    function automatic logic [2:0] ns_at(input int t);
        if (t < 10) return L_G;
        if (t < 13) return L_Y;
        return L_R;
    endfunction

    function automatic logic [2:0] ew_at(input int t);
        if (t < 13) return L_R;
        if (t < 23) return L_G;
        if (t < 26) return L_Y;
        return L_R;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] ns, input logic [2:0] ew,
                        input logic [3:0] exp_err, input logic clr);
        logic [3:0] want;
        {NS_red, NS_yellow, NS_green} = ns;
        {EW_red, EW_yellow, EW_green} = ew;
        clr_faults = clr;
        exp_q.push_back(exp_err);
        @(posedge clk);
        #1;
        clr_faults = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard: observed empty queue expected one entry");
        end else begin
            want = exp_q.pop_front();
            assert (err_pulse === want) else begin
                failures++;
                $error("FAIL err_pulse @%0t: observed %b expected %b", $time, err_pulse, want);
            end
        end
    endtask

    task automatic legal_period();
        for (int t = 0; t < 27; t++) step(ns_at(t), ew_at(t), 4'b0000, 1'b0);
    endtask

    // EW turns green one cycle early, overlapping NS's last yellow cycle.
    task automatic conflict_period(input logic clr);
        for (int t = 0; t < 27; t++) begin
            if (t == 12) step(L_Y, L_G, 4'b0010, clr);
            else if (t > 12 && t < 23) step(ns_at(t), L_G, 4'b0000, 1'b0);
            else step(ns_at(t), ew_at(t), 4'b0000, 1'b0);
        end
    endtask

    task automatic ew_cycle();
        repeat (10) step(L_R, L_G, 4'b0000, 1'b0);
        repeat (3)  step(L_R, L_Y, 4'b0000, 1'b0);
        step(L_R, L_R, 4'b0000, 1'b0);
    endtask

    task automatic check_state(input string tag);
        check({tag, " fault_vec"}, 32'(fault_vec), 32'(exp_fv));
        check({tag, " fault"},     32'(fault),     32'(|exp_fv));
        check({tag, " ns_cycles"}, 32'(ns_cycles), 32'(exp_ns));
        check({tag, " ew_cycles"}, 32'(ew_cycles), 32'(exp_ew));
    endtask

    initial begin
        rst = 1'b1;
        clr_faults = 1'b0;
        {NS_red, NS_yellow, NS_green} = L_R;
        {EW_red, EW_yellow, EW_green} = L_R;
        step(L_R, L_R, 4'b0000, 1'b0);
        step(L_R, L_R, 4'b0000, 1'b0);
        check_state("reset");
        rst = 1'b0;

        // Three legal signal cycles.
        repeat (3) legal_period();
        exp_ns = 3; exp_ew = 3;
        check_state("legal");

        // Single-cycle conflict.
        conflict_period(1'b0);
        exp_ns = 4; exp_ew = 4; exp_fv = 4'b0010;
        check_state("conflict");

        // NS yellow held 4 cycles: timing pulse on Y->R, count still advances.
        repeat (10) step(L_G, L_R, 4'b0000, 1'b0);
        repeat (4)  step(L_Y, L_R, 4'b0000, 1'b0);
        step(L_R, L_R, 4'b1000, 1'b0);
        ew_cycle();
        exp_ns = 5; exp_ew = 5; exp_fv = 4'b1010;
        check_state("yellow_long");

        // Clear the sticky flags.
        step(L_R, L_R, 4'b0000, 1'b1);
        exp_fv = 4'b0000;
        check_state("clear");

        // NS not one-hot for 2 cycles; the following 9-cycle green is not timed.
        for (int t = 0; t < 26; t++) step(ns_at(t), ew_at(t), 4'b0000, 1'b0);
        step(L_BAD, L_R, 4'b0001, 1'b0);
        step(L_BAD, L_R, 4'b0001, 1'b0);
        for (int t = 1; t < 27; t++) step(ns_at(t), ew_at(t), 4'b0000, 1'b0);
        exp_ns = 7; exp_ew = 7; exp_fv = 4'b0001;
        check_state("onehot");

        // NS green straight to red: sequence error, no count.
        repeat (12) step(L_G, L_R, 4'b0000, 1'b0);
        step(L_R, L_R, 4'b0100, 1'b0);
        ew_cycle();
        exp_ew = 8; exp_fv = 4'b0101;
        check_state("sequence");

        // NS green held 60 cycles: one timing pulse on the 51st green cycle.
        for (int k = 1; k <= 60; k++) step(L_G, L_R, (k == 51) ? 4'b1000 : 4'b0000, 1'b0);
        repeat (3) step(L_Y, L_R, 4'b0000, 1'b0);
        step(L_R, L_R, 4'b0000, 1'b0);
        ew_cycle();
        exp_ns = 8; exp_ew = 9; exp_fv = 4'b1101;
        check_state("green_long");

        // Clear coinciding with a conflict: the conflict survives.
        conflict_period(1'b1);
        exp_ns = 9; exp_ew = 10; exp_fv = 4'b0010;
        check_state("clear_conflict");

        // Reset in the middle of a green phase.
        for (int t = 0; t < 5; t++) step(ns_at(t), ew_at(t), 4'b0000, 1'b0);
        rst = 1'b1;
        step(L_G, L_R, 4'b0000, 1'b0);
        rst = 1'b0;
        exp_ns = 0; exp_ew = 0; exp_fv = 4'b0000;
        check_state("mid_reset");

        // The short green entered after reset is not timed; the yellow is.
        repeat (5) step(L_G, L_R, 4'b0000, 1'b0);
        repeat (3) step(L_Y, L_R, 4'b0000, 1'b0);
        step(L_R, L_R, 4'b0000, 1'b0);
        exp_ns = 1;
        check_state("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
